// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents:
//   - FSM state encoding (IDLE, BUSY, RESP).
//   - Requester identifiers. NONE is the idle grant value.
//   - Saturating increment for the 4-bit starve counters.
// Optional feature macro: MEM_ARB_RR_EN (see mem_port_arbiter.sv).
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] ID_UNCACHE = 2'd0;
    localparam logic [1:0] ID_DCACHE  = 2'd1;
    localparam logic [1:0] ID_ICACHE  = 2'd2;
    localparam logic [1:0] ID_NONE    = 2'd3;

    localparam int N_REQ = 3;

    // Counters stop at 15 rather than wrapping back to 0.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        if (v == 4'd15) begin
            return v;
        end else begin
            return v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory port arbiter.
// Ports:
//   active       - per-requester request vector (bit 0 = uncache).
//   starve_0..2  - starve counters (fixed-priority build only).
//   last_winner  - previous winner (round-robin build only).
//   winner       - index of the selected requester.
//   winner_valid - high when any requester is active.
// Macro MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
    parameter int STARVE_MAX = 8
)
`endif
(
    input  logic [2:0] active,
`ifdef MEM_ARB_RR_EN
    input  logic [1:0] last_winner,
`else
    input  logic [3:0] starve_0,
    input  logic [3:0] starve_1,
    input  logic [3:0] starve_2,
`endif
    output logic [1:0] winner,
    output logic       winner_valid
);

`ifdef MEM_ARB_RR_EN
    // Round-robin search starting just after the previous winner.
    always_comb begin
        winner       = ID_NONE;
        winner_valid = |active;
        case (last_winner)
            ID_UNCACHE: begin
                if (active[1])      winner = ID_DCACHE;
                else if (active[2]) winner = ID_ICACHE;
                else if (active[0]) winner = ID_UNCACHE;
                else                winner = ID_NONE;
            end
            ID_DCACHE: begin
                if (active[2])      winner = ID_ICACHE;
                else if (active[0]) winner = ID_UNCACHE;
                else if (active[1]) winner = ID_DCACHE;
                else                winner = ID_NONE;
            end
            default: begin
                if (active[0])      winner = ID_UNCACHE;
                else if (active[1]) winner = ID_DCACHE;
                else if (active[2]) winner = ID_ICACHE;
                else                winner = ID_NONE;
            end
        endcase
    end
`else
    logic [2:0] starved_s;

    // A requester that has lost too often overrides plain priority.
    always_comb begin
        starved_s[0] = active[0] && (int'(starve_0) >= STARVE_MAX);
        starved_s[1] = active[1] && (int'(starve_1) >= STARVE_MAX);
        starved_s[2] = active[2] && (int'(starve_2) >= STARVE_MAX);
    end

    // Starved requesters first (lowest index wins), then fixed 0 > 1 > 2.
    always_comb begin
        winner       = ID_NONE;
        winner_valid = 1'b1;
        if (starved_s[0])      winner = ID_UNCACHE;
        else if (starved_s[1]) winner = ID_DCACHE;
        else if (starved_s[2]) winner = ID_ICACHE;
        else if (active[0])    winner = ID_UNCACHE;
        else if (active[1])    winner = ID_DCACHE;
        else if (active[2])    winner = ID_ICACHE;
        else begin
            winner       = ID_NONE;
            winner_valid = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between uncache (0), dcache (1) and
// icache (2). One request is latched at a time and held until the
// downstream finish. Data and a one-cycle finish pulse then go back to the
// granted requester only.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset.
//   req_*_N                - requester N address/data/mask/we/re.
//   resp_data_N/finish_N   - response to requester N.
//   arb_addr/data/mask/we/re - latched downstream request.
//   in_arb_data/finish     - downstream response.
//   grant_id               - current owner, 3 when idle.
// Macro MEM_ARB_RR_EN: round-robin arbitration. When it is undefined, the
// arbiter uses fixed priority with a starvation override.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 8
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   req_addr_0,
    input  logic [DATA_W-1:0]   req_data_0,
    input  logic [DATA_W/8-1:0] req_mask_0,
    input  logic                req_we_0,
    input  logic                req_re_0,
    input  logic [ADDR_W-1:0]   req_addr_1,
    input  logic [DATA_W-1:0]   req_data_1,
    input  logic [DATA_W/8-1:0] req_mask_1,
    input  logic                req_we_1,
    input  logic                req_re_1,
    input  logic [ADDR_W-1:0]   req_addr_2,
    input  logic [DATA_W-1:0]   req_data_2,
    input  logic [DATA_W/8-1:0] req_mask_2,
    input  logic                req_we_2,
    input  logic                req_re_2,
    output logic [DATA_W-1:0]   resp_data_0,
    output logic                resp_finish_0,
    output logic [DATA_W-1:0]   resp_data_1,
    output logic                resp_finish_1,
    output logic [DATA_W-1:0]   resp_data_2,
    output logic                resp_finish_2,
    output logic [ADDR_W-1:0]   arb_addr,
    output logic [DATA_W-1:0]   arb_data,
    output logic [DATA_W/8-1:0] arb_mask,
    output logic                arb_we,
    output logic                arb_re,
    input  logic [DATA_W-1:0]   in_arb_data,
    input  logic                in_arb_finish,
    output logic [1:0]          grant_id
);

    arb_state_e          state_r, state_s;
    logic [2:0]          active_s;
    logic [1:0]          winner_s;
    logic                winner_valid_s;
    logic                grant_s;
    logic                finish_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [DATA_W/8-1:0] sel_mask_s;
    logic                sel_we_s;
    logic                sel_re_s;
    logic [ADDR_W-1:0]   lat_addr_r;
    logic [DATA_W-1:0]   lat_data_r;
    logic [DATA_W/8-1:0] lat_mask_r;
    logic                arb_we_r;
    logic                arb_re_r;
    logic [1:0]          grant_id_r;
    logic [1:0]          owner_r;
    logic [2:0]          resp_finish_r;
    logic [DATA_W-1:0]   resp_data_r [N_REQ];
`ifdef MEM_ARB_RR_EN
    logic [1:0]          last_winner_r;
`else
    logic [3:0]          starve_r [N_REQ];
`endif

    // Request detection and event strobes.
    always_comb begin
        active_s[0] = req_we_0 | req_re_0;
        active_s[1] = req_we_1 | req_re_1;
        active_s[2] = req_we_2 | req_re_2;
        grant_s     = (state_r == ST_IDLE) && winner_valid_s;
        finish_s    = (state_r == ST_BUSY) && in_arb_finish;
    end

    mem_arb_pick
`ifndef MEM_ARB_RR_EN
        #(.STARVE_MAX(STARVE_MAX))
`endif
        u_pick (
            .active       (active_s),
`ifdef MEM_ARB_RR_EN
            .last_winner  (last_winner_r),
`else
            .starve_0     (starve_r[0]),
            .starve_1     (starve_r[1]),
            .starve_2     (starve_r[2]),
`endif
            .winner       (winner_s),
            .winner_valid (winner_valid_s)
        );

    // Route the winning requester's fields towards the request latch.
    always_comb begin
        sel_addr_s = req_addr_0;
        sel_data_s = req_data_0;
        sel_mask_s = req_mask_0;
        sel_we_s   = req_we_0;
        sel_re_s   = req_re_0;
        case (winner_s)
            ID_DCACHE: begin
                sel_addr_s = req_addr_1;
                sel_data_s = req_data_1;
                sel_mask_s = req_mask_1;
                sel_we_s   = req_we_1;
                sel_re_s   = req_re_1;
            end
            ID_ICACHE: begin
                sel_addr_s = req_addr_2;
                sel_data_s = req_data_2;
                sel_mask_s = req_mask_2;
                sel_we_s   = req_we_2;
                sel_re_s   = req_re_2;
            end
            default: begin
                sel_addr_s = req_addr_0;
                sel_data_s = req_data_0;
                sel_mask_s = req_mask_0;
                sel_we_s   = req_we_0;
                sel_re_s   = req_re_0;
            end
        endcase
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (winner_valid_s) state_s = ST_BUSY;
                else                state_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (in_arb_finish) state_s = ST_RESP;
                else               state_s = ST_BUSY;
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch. A combined write+read is issued as a write only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr_r <= {ADDR_W{1'b0}};
            lat_data_r <= {DATA_W{1'b0}};
            lat_mask_r <= {(DATA_W/8){1'b0}};
            arb_we_r   <= 1'b0;
            arb_re_r   <= 1'b0;
        end else if (grant_s) begin
            lat_addr_r <= sel_addr_s;
            lat_data_r <= sel_data_s;
            lat_mask_r <= sel_mask_s;
            arb_we_r   <= sel_we_s;
            arb_re_r   <= sel_re_s & ~sel_we_s;
        end else if (finish_s) begin
            arb_we_r   <= 1'b0;
            arb_re_r   <= 1'b0;
        end
    end

    // Owner tracking. grant_id drops to NONE on entry to RESP, while
    // owner_r still steers the response pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id_r <= ID_NONE;
            owner_r    <= ID_NONE;
        end else if (grant_s) begin
            grant_id_r <= winner_s;
            owner_r    <= winner_s;
        end else if (finish_s) begin
            grant_id_r <= ID_NONE;
        end
    end

    // One-cycle response to the owner. Writes return zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_finish_r <= 3'b000;
            for (int i = 0; i < N_REQ; i++) resp_data_r[i] <= {DATA_W{1'b0}};
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                resp_finish_r[i] <= finish_s && (owner_r == 2'(i));
                resp_data_r[i]   <= (finish_s && (owner_r == 2'(i)) && !arb_we_r)
                                    ? in_arb_data : {DATA_W{1'b0}};
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the last winner. After reset it is 2, so the first search
    // starts at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_r <= ID_ICACHE;
        end else if (grant_s) begin
            last_winner_r <= winner_s;
        end
    end
`else
    // Starve counters: cleared on a win, saturating increment on a loss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) starve_r[i] <= 4'd0;
        end else if (grant_s) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (winner_s == 2'(i))  starve_r[i] <= 4'd0;
                else if (active_s[i])   starve_r[i] <= sat_inc4(starve_r[i]);
                else                    starve_r[i] <= starve_r[i];
            end
        end
    end
`endif

    assign arb_addr      = lat_addr_r;
    assign arb_data      = lat_data_r;
    assign arb_mask      = lat_mask_r;
    assign arb_we        = arb_we_r;
    assign arb_re        = arb_re_r;
    assign grant_id      = grant_id_r;
    assign resp_finish_0 = resp_finish_r[0];
    assign resp_finish_1 = resp_finish_r[1];
    assign resp_finish_2 = resp_finish_r[2];
    assign resp_data_0   = resp_data_r[0];
    assign resp_data_1   = resp_data_r[1];
    assign resp_data_2   = resp_data_r[2];

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single downstream memory/bus port between three requesters: the uncached/MMIO path, the data cache and the instruction cache. It latches one request at a time and holds the grant until the downstream port signals `finish`. It returns the read data and a one-cycle `finish` pulse only to the granted requester. It sits between the cache/uncache front ends and the AXI4 master bridge.

## Interface
Parameters:
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, data width; the mask width is `DATA_W/8`.
- `STARVE_MAX`, 8, number of consecutive lost arbitrations before a requester is forced to win (fixed-priority mode only).

Ports (requester index 0 = uncache, 1 = dcache, 2 = icache):
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `req_addr_N` in `ADDR_W`, N=0..2: request address.
- `req_data_N` in `DATA_W`: write data.
- `req_mask_N` in `DATA_W/8`: byte strobes.
- `req_we_N` in 1: write request.
- `req_re_N` in 1: read request.
- `resp_data_N` out `DATA_W`: read data, valid while `resp_finish_N`=1.
- `resp_finish_N` out 1: one-cycle completion pulse.
- `arb_addr` out `ADDR_W`, `arb_data` out `DATA_W`, `arb_mask` out `DATA_W/8`, `arb_we` out 1, `arb_re` out 1: downstream request.
- `in_arb_data` in `DATA_W`: downstream read data.
- `in_arb_finish` in 1: downstream completion, one-cycle pulse.
- `grant_id` out 2: current owner. 3 means none. Debug/perf use.

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE: a requester is active when `we|re`=1. If `we` and `re` are both set, the request is treated as a write. If any requester is active, select a winner, register its addr/data/mask/we/re into the request latch, set `grant_id`, and go to BUSY.
- Fixed priority: 0 > 1 > 2.
  - Each requester has a 4-bit starve counter.
  - The counter increments when the requester is active in IDLE and loses.
  - It clears when the requester wins.
  - A requester whose counter is ≥ `STARVE_MAX` wins over all others. If two requesters qualify, the lower index wins.
- BUSY:
  - `arb_we`/`arb_re`/addr/data/mask are driven from the latch, not from live inputs.
  - Requester inputs may change or drop; the latched transaction still completes.
  - On `in_arb_finish`=1: capture `in_arb_data` into the response register and go to RESP.
- RESP:
  - Pulse `resp_finish_g`=1 for the granted requester g, with `resp_data_g` equal to the captured data.
  - Deassert `arb_we`/`arb_re`, set `grant_id`=3, return to IDLE.
  - For writes, `resp_data_g`=0.
- All non-granted `resp_finish` outputs are 0 at all times, and all `resp_data` outputs are 0 when not finishing.
- Requesters must keep their request asserted until `resp_finish`. A request still held in the cycle after `resp_finish` is treated as a new transaction.
- An `in_arb_finish` arriving in IDLE or RESP is ignored.

## Timing
- Reset values: all `arb_*`=0, all `resp_*`=0, `grant_id`=3, state IDLE, starve counters 0. Reset takes effect immediately, including mid-transaction; no finish pulse is issued for the aborted transaction.
- A request sampled in IDLE at edge k drives `arb_re`/`arb_we` from cycle k+1.
- If `in_arb_finish` is high in cycle m, `resp_finish` is high in cycle m+1.
- Minimum turnaround is 3 cycles (IDLE→BUSY→RESP) for a zero-wait downstream.
- Back-to-back grants: at least one IDLE cycle separates successive transactions, so `arb_re`/`arb_we` go low for ≥1 cycle.
- Starve counters saturate at 15; they do not wrap.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration replaces fixed priority.
  - The search starts at (last_winner+1) mod 3.
  - Starve counters and `STARVE_MAX` are not instantiated.
  - Reset last_winner is 2, so requester 0 gets first priority.
- `MEM_ARB_RR_EN` undefined: fixed priority with starvation override, as described under Operation.

## Structure
- Shared package/defines file:
  - State encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Requester IDs UNCACHE=2'd0, DCACHE=2'd1, ICACHE=2'd2, NONE=2'd3.
- One sub-module, `mem_arb_pick`: combinational winner select. Inputs are the active vector, starve counters or last_winner; output is the winner index plus a valid flag. The FSM, latches and counters live in the top module.

## Test plan
- Single dcache read, addr 0x8000_0010, downstream finish after 4 cycles with data 0xDEAD_BEEF_0123_4567 → `arb_re` high for 4 cycles; `resp_finish_1` pulses once with that data; `grant_id` sequence 3,1,1,1,1,3.
- All three requesters read simultaneously, fixed priority → grant order 0,1,2; each gets exactly one finish pulse.
- Uncache requests continuously and icache stays active, `STARVE_MAX`=8 → icache wins on its 9th arbitration.
- `MEM_ARB_RR_EN` defined, all three continuously active → grant order 0,1,2,0,1,2.
- dcache write (data 0x11, mask 0x01) is dropped in BUSY; `in_arb_finish` arrives 2 cycles later → `arb_we` held until finish; `resp_finish_1` still pulses; `resp_data_1`=0.
- `rst` asserted in BUSY → all outputs 0 and `grant_id`=3 in the same cycle; a later `in_arb_finish` produces no response.
